// File: rtl/rom_arbiter.sv
// Two-requester (fetch/load) round-robin arbiter in front of a 1-cycle registered ROM.
// Optional alignment checking is enabled by defining ROM_ARB_ALIGN_CHK_EN.
module rom_arbiter #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    input  logic              if_rready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_rerr,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    input  logic              ld_rready,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_rerr,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

    state_t            state, state_nxt;
    logic              owner;        // 0 = fetch, 1 = load
    logic              last_owner;
    logic              err_q;
    logic [DATA_W-1:0] hold_q;

    logic              owner_rready;
    logic              gnt_any;
    logic              sel;
    logic [ADDR_W-1:0] gnt_addr;
    logic              misaligned;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        owner_rready = owner ? ld_rready : if_rready;
        sel          = (if_req && ld_req) ? ~last_owner : ld_req;
        gnt_addr     = sel ? ld_addr : if_addr;
        gnt_any      = !reset && (if_req || ld_req) && (state == IDLE || owner_rready);
`ifdef ROM_ARB_ALIGN_CHK_EN
        misaligned   = (gnt_addr[1:0] != 2'b00);
`else
        misaligned   = 1'b0;
`endif
        if_gnt       = gnt_any && !sel;
        ld_gnt       = gnt_any && sel;
        rom_en       = gnt_any && !misaligned;
        rom_addr     = rom_en ? gnt_addr : '0;
    end

    // Response path: live ROM word in RESP, captured copy in HOLD; all zero under reset.
    always_comb begin
        resp_valid = !reset && (state != IDLE);
        resp_data  = '0;
        if (state == RESP)
            resp_data = err_q ? '0 : rom_data;
        else if (state == HOLD)
            resp_data = hold_q;
        if_rvalid = resp_valid && !owner;
        ld_rvalid = resp_valid && owner;
        if_rdata  = if_rvalid ? resp_data : '0;
        ld_rdata  = ld_rvalid ? resp_data : '0;
`ifdef ROM_ARB_ALIGN_CHK_EN
        if_rerr   = if_rvalid && err_q;
        ld_rerr   = ld_rvalid && err_q;
`else
        if_rerr   = 1'b0;
        ld_rerr   = 1'b0;
`endif
    end

    always_comb begin
        state_nxt = state;
        if (gnt_any)
            state_nxt = RESP;
        else if (state != IDLE)
            state_nxt = owner_rready ? IDLE : HOLD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            err_q      <= 1'b0;
            hold_q     <= '0;
        end else begin
            state <= state_nxt;
            if (state == RESP)
                hold_q <= err_q ? '0 : rom_data;
            if (gnt_any) begin
                owner      <= sel;
                last_owner <= sel;
                err_q      <= misaligned;
            end
        end
    end

endmodule
